// File: rtl/bcd_counter_ctrl_pkg.sv
// Shared encodings and helpers for the push-button BCD counter controller.
// Mode/direction encodings, button priority indices and single-digit BCD arithmetic.
package bcd_counter_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_EDIT = 2'd2
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Bit positions in the conditioned button vector; higher index wins.
    localparam int BTN_IDX_D = 0;
    localparam int BTN_IDX_U = 1;
    localparam int BTN_IDX_R = 2;
    localparam int BTN_IDX_L = 3;
    localparam int BTN_IDX_C = 4;
    localparam int NUM_BTNS  = 5;

    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_C,
        BTN_L,
        BTN_R,
        BTN_U,
        BTN_D
    } btn_e;

    function automatic btn_e pick_btn(input logic [NUM_BTNS-1:0] edges);
        if (edges[BTN_IDX_C]) return BTN_C;
        if (edges[BTN_IDX_L]) return BTN_L;
        if (edges[BTN_IDX_R]) return BTN_R;
        if (edges[BTN_IDX_U]) return BTN_U;
        if (edges[BTN_IDX_D]) return BTN_D;
        return BTN_NONE;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] v);
        return (v == 4'd9) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'd9 : v - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_counter_ctrl_if.sv
// Button inputs and display outputs of the BCD counter controller.
// The board/bench side drives buttons (master); the controller drives the display (slave).
interface bcd_counter_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    I_BTNU;
    logic                    I_BTNL;
    logic                    I_BTNC;
    logic                    I_BTNR;
    logic                    I_BTND;
    logic [4*NUM_DIGITS-1:0] O_DIGITS;
    logic [NUM_DIGITS-1:0]   O_LEDDRVEN;
    logic [NUM_DIGITS-1:0]   O_LEDDOTS;
    logic [1:0]              O_MODE;
    logic                    O_WRAP;

    modport master (
        output I_BTNU, I_BTNL, I_BTNC, I_BTNR, I_BTND,
        input  O_DIGITS, O_LEDDRVEN, O_LEDDOTS, O_MODE, O_WRAP
    );

    modport slave (
        input  I_BTNU, I_BTNL, I_BTNC, I_BTNR, I_BTND,
        output O_DIGITS, O_LEDDRVEN, O_LEDDOTS, O_MODE, O_WRAP
    );
endinterface

// File: rtl/bcd_counter_ctrl_digit.sv
// One BCD digit: load, increment or decrement, with carry/borrow out for ripple chaining.
// Load has priority; carry/borrow only report a step that actually happens.
module bcd_digit
    import bcd_counter_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] value_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] value_q;
    logic [3:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = bcd_inc(value_q);
        end else if (dec_i) begin
            value_d = bcd_dec(value_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign carry_o  = inc_i & ~load_i & (value_q == 4'd9);
    assign borrow_o = dec_i & ~load_i & ~inc_i & (value_q == 4'd0);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// NUM_DIGITS-digit BCD counter controlled by five push buttons (IDLE / RUN / EDIT).
// Holds button conditioning, mode FSM, prescaler, blink timer, cursor and registered display outputs.
module bcd_counter_ctrl
    import bcd_counter_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int BLINK_DIV  = 250
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    bcd_counter_ctrl_if.slave  bus
);

    localparam int CUR_W = $clog2(NUM_DIGITS);
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV);

    // Button conditioning: 2-flop synchroniser then rising-edge detect.
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_BTNS-1:0] btn_edges;
    btn_e                btn;

    assign btn_raw[BTN_IDX_C] = bus.I_BTNC;
    assign btn_raw[BTN_IDX_L] = bus.I_BTNL;
    assign btn_raw[BTN_IDX_R] = bus.I_BTNR;
    assign btn_raw[BTN_IDX_U] = bus.I_BTNU;
    assign btn_raw[BTN_IDX_D] = bus.I_BTND;
    assign btn_edges          = sync2_q & ~prev_q;
    assign btn                = pick_btn(btn_edges);

    // Control state
    mode_e              mode_q, mode_d;
    dir_e               dir_q, dir_d;
    logic [CUR_W-1:0]   cursor_q, cursor_d;
    logic [PRE_W-1:0]   presc_q, presc_d;
    logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q, blink_ph_d;

    // Registered display outputs
    logic [NUM_DIGITS-1:0] drven_q, drven_d;
    logic [NUM_DIGITS-1:0] dots_q, dots_d;
    logic                  wrap_q, wrap_d;

    // Digit datapath controls
    logic                  step_up, step_dn;
    logic                  edit_load;
    logic [3:0]            edit_val;
    logic [3:0]            digit_val [NUM_DIGITS];
    logic [NUM_DIGITS:0]   inc_chain, dec_chain;
    logic [3:0]            cur_digit;

    assign cur_digit = digit_val[cursor_q];

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        mode_d      = mode_q;
        dir_d       = dir_q;
        cursor_d    = cursor_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        edit_load   = 1'b0;
        edit_val    = cur_digit;

        unique case (mode_q)
            MODE_IDLE: begin
                if (btn == BTN_C) begin
                    mode_d  = MODE_RUN;
                    presc_d = '0;
                end else if (btn == BTN_L || btn == BTN_R) begin
                    mode_d      = MODE_EDIT;
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b1;
                end
            end

            MODE_RUN: begin
                if (btn == BTN_C) begin
                    mode_d = MODE_IDLE;
                end else begin
                    if (btn == BTN_U) dir_d = DIR_UP;
                    if (btn == BTN_D) dir_d = DIR_DN;
                    // A tick coinciding with a direction change still steps the old way.
                    if (presc_q == PRE_W'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        step_up = (dir_q == DIR_UP);
                        step_dn = (dir_q == DIR_DN);
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
            end

            MODE_EDIT: begin
                if (btn == BTN_C) begin
                    mode_d = MODE_IDLE;
                end else begin
                    if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                        blink_cnt_d = '0;
                        blink_ph_d  = ~blink_ph_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLK_W'(1);
                    end
                    unique case (btn)
                        BTN_L: cursor_d = (cursor_q == CUR_W'(NUM_DIGITS - 1)) ? '0
                                          : cursor_q + CUR_W'(1);
                        BTN_R: cursor_d = (cursor_q == '0) ? CUR_W'(NUM_DIGITS - 1)
                                          : cursor_q - CUR_W'(1);
                        BTN_U: begin
                            edit_load = 1'b1;
                            edit_val  = bcd_inc(cur_digit);
                        end
                        BTN_D: begin
                            edit_load = 1'b1;
                            edit_val  = bcd_dec(cur_digit);
                        end
                        default: ;
                    endcase
                end
            end

            default: mode_d = MODE_IDLE;
        endcase
    end

    // Output decode, registered so the display sees clean levels
    always_comb begin
        drven_d = '1;
        dots_d  = '0;
        unique case (mode_d)
            MODE_EDIT: begin
                drven_d[cursor_d] = blink_ph_d;
                dots_d[cursor_d]  = 1'b1;
            end
            MODE_RUN:  dots_d[0] = (dir_d == DIR_DN);
            default:   ;
        endcase
        wrap_d = inc_chain[NUM_DIGITS] | dec_chain[NUM_DIGITS];
    end

    // State register
    // NOTE: reset is synchronous and covers every flop, so a pending button edge is dropped too.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            mode_q      <= MODE_IDLE;
            dir_q       <= DIR_UP;
            cursor_q    <= '0;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b1;
            drven_q     <= '1;
            dots_q      <= '0;
            wrap_q      <= 1'b0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            cursor_q    <= cursor_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            drven_q     <= drven_d;
            dots_q      <= dots_d;
            wrap_q      <= wrap_d;
        end
    end

    // Ripple carry/borrow chain across the digits
    assign inc_chain[0] = step_up;
    assign dec_chain[0] = step_dn;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (I_CLK),
            .rst_i      (I_RESET),
            .inc_i      (inc_chain[i]),
            .dec_i      (dec_chain[i]),
            .load_i     (edit_load && (cursor_q == CUR_W'(i))),
            .load_val_i (edit_val),
            .value_o    (digit_val[i]),
            .carry_o    (inc_chain[i+1]),
            .borrow_o   (dec_chain[i+1])
        );
    end

    logic [4*NUM_DIGITS-1:0] digits_flat;

    always_comb begin
        digits_flat = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits_flat[4*i +: 4] = digit_val[i];
        end
    end

    assign bus.O_DIGITS   = digits_flat;
    assign bus.O_LEDDRVEN = drven_q;
    assign bus.O_LEDDOTS  = dots_q;
    assign bus.O_MODE     = mode_q;
    assign bus.O_WRAP     = wrap_q;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Scoreboard bench for bcd_counter_ctrl: a value-level reference model predicts each cycle's outputs,
// and a monitor on the falling edge compares them with the DUT.
module tb_bcd_counter_ctrl;

    localparam int ND   = 4;
    localparam int TD   = 4;
    localparam int BD   = 4;
    localparam int MAXV = 10 ** ND;

    // Button masks, ordered {C, L, R, U, D}
    localparam logic [4:0] B_C = 5'b10000;
    localparam logic [4:0] B_L = 5'b01000;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b00010;
    localparam logic [4:0] B_D = 5'b00001;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_counter_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    bcd_counter_ctrl #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .BLINK_DIV  (BD)
    ) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [4*ND-1:0] digits;
        logic [1:0]      mode;
        logic [ND-1:0]   drven;
        logic [ND-1:0]   dots;
        logic            wrap;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cyc  = 0;

    // Reference model state: counter as an integer, timers as elapsed-cycle counts
    int         m_val, m_mode, m_dir, m_cur, m_run_cyc, m_edit_cyc;
    logic       m_wrap;
    logic [4:0] p1, p2, p3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, n_cyc, act, exp);
        end
    endtask

    function automatic logic [4*ND-1:0] to_bcd(input int v);
        logic [4*ND-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic edit_digit(input int delta);
        int pw, d, nd;
        pw = 1;
        for (int i = 0; i < m_cur; i++) pw = pw * 10;
        d     = (m_val / pw) % 10;
        nd    = (d + delta + 10) % 10;
        m_val = m_val + (nd - d) * pw;
    endtask

    task automatic model_step(input logic [4:0] b, input logic r);
        logic [4:0] act;
        int         sel;
        int         step_dir;
        exp_t       e;
        m_wrap = 1'b0;
        if (r) begin
            m_val = 0; m_mode = 0; m_dir = 0; m_cur = 0;
            m_run_cyc = 0; m_edit_cyc = 0;
            p1 = '0; p2 = '0; p3 = '0;
        end else begin
            // A press sampled two edges ago, that was low three edges ago, acts now
            act = p2 & ~p3;
            sel = -1;
            for (int i = 4; i >= 0; i--) if (act[i] && sel < 0) sel = i;
            case (m_mode)
                0: begin
                    if (sel == 4) begin
                        m_mode = 1; m_run_cyc = 0;
                    end else if (sel == 3 || sel == 2) begin
                        m_mode = 2; m_edit_cyc = 0;
                    end
                end
                1: begin
                    if (sel == 4) begin
                        m_mode = 0;
                    end else begin
                        step_dir = m_dir;
                        if (sel == 1) m_dir = 0;
                        if (sel == 0) m_dir = 1;
                        m_run_cyc++;
                        if (m_run_cyc % TD == 0) begin
                            if (step_dir == 0) begin
                                m_wrap = (m_val == MAXV - 1);
                                m_val  = (m_val + 1) % MAXV;
                            end else begin
                                m_wrap = (m_val == 0);
                                m_val  = (m_val + MAXV - 1) % MAXV;
                            end
                        end
                    end
                end
                default: begin
                    if (sel == 4) begin
                        m_mode = 0;
                    end else begin
                        m_edit_cyc++;
                        case (sel)
                            3: m_cur = (m_cur + 1) % ND;
                            2: m_cur = (m_cur + ND - 1) % ND;
                            1: edit_digit(1);
                            0: edit_digit(-1);
                            default: ;
                        endcase
                    end
                end
            endcase
            p3 = p2; p2 = p1; p1 = b;
        end

        e.digits = to_bcd(m_val);
        e.mode   = 2'(m_mode);
        e.drven  = '1;
        e.dots   = '0;
        e.wrap   = m_wrap;
        if (m_mode == 2) begin
            e.drven[m_cur] = ((m_edit_cyc / BD) % 2) == 0;
            e.dots[m_cur]  = 1'b1;
        end else if (m_mode == 1) begin
            e.dots[0] = (m_dir == 1);
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic [4:0] b, input logic r);
        {bus.I_BTNC, bus.I_BTNL, bus.I_BTNR, bus.I_BTNU, bus.I_BTND} = b;
        rst = r;
        @(posedge clk);
        model_step(b, r);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(5'b0, 1'b0);
    endtask

    task automatic press(input logic [4:0] b);
        cyc(b, 1'b0);
        cyc(5'b0, 1'b0);
    endtask

    // Monitor: compares each predicted snapshot with the DUT away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("digits", 32'(bus.O_DIGITS),   32'(e.digits));
                check("mode",   32'(bus.O_MODE),     32'(e.mode));
                check("drven",  32'(bus.O_LEDDRVEN), 32'(e.drven));
                check("dots",   32'(bus.O_LEDDOTS),  32'(e.dots));
                check("wrap",   32'(bus.O_WRAP),     32'(e.wrap));
            end
        end
    end

    initial begin
        // Reset, then quiet idle
        repeat (3) cyc(5'b0, 1'b1);
        idle(20);

        // Hold C: enter RUN once, count, then stop
        repeat (3) cyc(B_C, 1'b0);
        idle(14);
        press(B_C);
        idle(5);

        // Preload 9999 through EDIT, run up across the wrap, then down across it
        cyc(5'b0, 1'b1);
        idle(2);
        press(B_L);
        for (int i = 0; i < ND; i++) begin
            press(B_D);
            press(B_L);
        end
        press(B_C);
        press(B_C);
        idle(12);
        press(B_D);
        idle(12);
        press(B_C);

        // Cursor wrap, digit edit without carry, blink timing
        press(B_L);
        press(B_R);
        press(B_U);
        press(B_U);
        idle(12);

        // Held button acts once
        repeat (10) cyc(B_U, 1'b0);
        idle(3);
        press(B_C);
        idle(3);

        // Simultaneous U and C in IDLE: only C acts
        cyc(B_U | B_C, 1'b0);
        idle(10);

        // Reset mid-RUN
        cyc(5'b0, 1'b1);
        idle(6);

        // Randomised button activity with occasional resets
        for (int i = 0; i < 1500; i++) begin
            logic [4:0] b;
            for (int j = 0; j < 5; j++) b[j] = ($urandom_range(0, 7) == 0);
            cyc(b, $urandom_range(0, 399) == 0);
        end

        idle(2);
        @(negedge clk);
        @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
